// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: resolves both ALU operands through
// EX/MEM/WB forwarding, inserts load-use bubbles, and honours hold and flush.
module id_ex_stage #(
    parameter int PC_W   = 32,
    parameter int ALUC_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic              id_a_sel,
    input  logic              id_b_sel,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wreg_en,
    input  logic [4:0]        id_wreg_addr,
    input  logic              id_mem_read,
    input  logic              id_mem_write,

    input  logic [31:0]       ex_result,
    input  logic              mem_wreg_en,
    input  logic [4:0]        mem_wreg_addr,
    input  logic [31:0]       mem_result,
    input  logic              wb_wreg_en,
    input  logic [4:0]        wb_wreg_addr,
    input  logic [31:0]       wb_result,

    input  logic              ex_hold,
    input  logic              flush,

    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [ALUC_W-1:0] ex_aluc,
    output logic [31:0]       ex_store_data,
    output logic              ex_wreg_en,
    output logic [4:0]        ex_wreg_addr,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              id_stall
);

    logic        ex_fwd_ok;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [31:0] next_a;
    logic [31:0] next_b;
    logic        rs_hazard;
    logic        rt_hazard;
    logic        luse;
    logic        load_bubble;
    logic        load_fields;

    // A load in EX has no data yet, so only non-load EX writers can forward.
    assign ex_fwd_ok = ex_valid & ex_wreg_en & ~ex_mem_read;

    always_comb begin
        fwd_rs = id_rs_data;
        if (id_rs == 5'd0)
            fwd_rs = 32'd0;
        else if (ex_fwd_ok && (ex_wreg_addr == id_rs))
            fwd_rs = ex_result;
        else if (mem_wreg_en && (mem_wreg_addr == id_rs))
            fwd_rs = mem_result;
        else if (wb_wreg_en && (wb_wreg_addr == id_rs))
            fwd_rs = wb_result;
    end

    always_comb begin
        fwd_rt = id_rt_data;
        if (id_rt == 5'd0)
            fwd_rt = 32'd0;
        else if (ex_fwd_ok && (ex_wreg_addr == id_rt))
            fwd_rt = ex_result;
        else if (mem_wreg_en && (mem_wreg_addr == id_rt))
            fwd_rt = mem_result;
        else if (wb_wreg_en && (wb_wreg_addr == id_rt))
            fwd_rt = wb_result;
    end

    assign next_a = id_a_sel ? {27'd0, id_shamt} : fwd_rs;
    assign next_b = id_b_sel ? id_imm : fwd_rt;

    assign rs_hazard = id_uses_rs & (id_rs == ex_wreg_addr);
    assign rt_hazard = id_uses_rt & (id_rt == ex_wreg_addr);
    assign luse      = id_valid & ex_valid & ex_mem_read & (ex_wreg_addr != 5'd0)
                     & (rs_hazard | rt_hazard);

    assign id_stall = ex_hold | (luse & ~flush);

    // Flush beats hold; a held register ignores the load-use hazard entirely.
    assign load_bubble = rst | flush | (~ex_hold & luse);
    assign load_fields = ~ex_hold & ~luse;

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_a          <= 32'd0;
            ex_b          <= 32'd0;
            ex_aluc       <= '0;
            ex_store_data <= 32'd0;
            ex_wreg_en    <= 1'b0;
            ex_wreg_addr  <= 5'd0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
        end else if (load_fields) begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_a          <= next_a;
            ex_b          <= next_b;
            ex_aluc       <= id_aluc;
            ex_store_data <= fwd_rt;
            ex_wreg_en    <= id_wreg_en & id_valid;
            ex_wreg_addr  <= id_wreg_addr;
            ex_mem_read   <= id_mem_read & id_valid;
            ex_mem_write  <= id_mem_write & id_valid;
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Pipeline register between decode and execute. It resolves both ALU operands with full forwarding and registers them with the ALU opcode, so the combinational ALU in EX takes its inputs directly from this register. It detects load-use hazards and inserts a one-cycle bubble. It also honours a downstream hold and a branch flush.

Parameters:
- PC_W, 32, width of the carried PC.
- ALUC_W, 4, ALU opcode width; `ALU_* encodings from define.vh.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_pc  in  PC_W  decode PC
- id_rs, id_rt  in  5  source register indices
- id_rs_data, id_rt_data  in  32  register-file read data
- id_imm  in  32  extended immediate
- id_shamt  in  5  shift amount
- id_aluc  in  ALUC_W  ALU opcode
- id_a_sel  in  1  0: A=rs, 1: A={27'b0,shamt}
- id_b_sel  in  1  0: B=rt, 1: B=imm
- id_uses_rs, id_uses_rt  in  1  the source is actually read
- id_wreg_en  in  1  instruction writes the register file
- id_wreg_addr  in  5  destination register
- id_mem_read, id_mem_write  in  1  load / store
- ex_result  in  32  ALU result of the instruction held in this register
- mem_wreg_en  in  1  MEM-stage write enable
- mem_wreg_addr  in  5  MEM-stage destination
- mem_result  in  32  MEM-stage final value (load data for loads)
- wb_wreg_en, wb_wreg_addr, wb_result  in  1/5/32  WB-stage write
- ex_hold  in  1  downstream stall
- flush  in  1  branch redirect; kill the decode instruction
- ex_valid, ex_pc, ex_a, ex_b, ex_aluc, ex_store_data, ex_wreg_en, ex_wreg_addr, ex_mem_read, ex_mem_write  out  registered EX-stage fields
- id_stall  out  1  combinational; decode must hold its instruction

Behaviour:
- Reset: every output register is 0, including ex_valid, ex_wreg_en, ex_mem_read and ex_mem_write.
- Forwarding (combinational, per source: rs, and rt):
  - Index 0 always yields 0.
  - Otherwise the first match wins:
    - EX: ex_valid & ex_wreg_en & !ex_mem_read & ex_wreg_addr==idx -> ex_result.
    - MEM: mem_wreg_en & mem_wreg_addr==idx -> mem_result.
    - WB: wb_wreg_en & wb_wreg_addr==idx -> wb_result.
    - None matching -> register-file data.
- Operand selection:
  - ex_a = id_a_sel ? {27'b0,id_shamt} : fwd_rs.
  - ex_b = id_b_sel ? id_imm : fwd_rt.
  - ex_store_data = fwd_rt.
- Load-use hazard: luse = id_valid & ex_valid & ex_mem_read & ex_wreg_addr!=0 & ((id_uses_rs & id_rs==ex_wreg_addr) | (id_uses_rt & id_rt==ex_wreg_addr)).
- id_stall = ex_hold | (luse & !flush).
- Register update at each rising clk, first matching rule applies:
  1. rst: clear all outputs.
  2. flush: load a bubble (ex_valid, ex_wreg_en, ex_mem_read, ex_mem_write = 0; data fields 0). Flush overrides ex_hold.
  3. ex_hold: keep every output unchanged.
  4. luse: load a bubble.
  5. Otherwise load all fields. ex_valid = id_valid, and the control enables are ANDed with id_valid.
- Latency: one cycle from decode to the registered outputs.
- A load-use stall lasts exactly one cycle. The load then sits in MEM and its data forwards from mem_result.
- Operands are sampled only on a load cycle. Values forwarded during a hold are not retained.
- A bubble never matches any forwarding comparison, because its ex_valid is 0.

Test Plan:
- After reset, drive addu $3,$1,$2 with rf $1=5, $2=7, no forwards; next cycle -> ex_a=5, ex_b=7, ex_aluc=`ALU_ADDU, ex_valid=1.
- EX holds a $3 write with ex_result=0x10; MEM also writes $3 with 0x20; decode reads rs=$3 -> ex_a=0x10 (EX wins over MEM). Repeat with rs=$0 and a matching $0 writer -> ex_a=0.
- EX holds a load to $4; decode uses rt=$4 -> id_stall=1 for one cycle and ex_valid=0 next. The following cycle, with mem_result=0xCAFE -> ex_b=0xCAFE.
- sll with shamt=3 (id_a_sel=1) -> ex_a=3. lui with imm=0x1234 (id_b_sel=1) -> ex_b=0x00001234 and ex_aluc=`ALU_LUI.
- ex_hold=1 for 3 cycles while decode changes -> outputs frozen and id_stall=1. Raise flush during the hold -> next cycle is a bubble.
- Assert rst while a valid store is in the register -> next cycle all outputs are 0 and ex_mem_write=0.
